// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared opcode, ALU-op and control-bundle definitions for the
//                5-stage MIPS core.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    // Controls that travel down the pipe into EX
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       alu_src;
        logic [1:0] alu_op;
    } ex_ctrl_t;

    // Full decoder result; the extra fields are consumed inside ID only
    typedef struct packed {
        ex_ctrl_t   ex;
        logic       reg_dst;
        logic       zero_ext;
        logic       uses_rt;
        logic       illegal;
    } dec_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/main_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : main_decoder
//  Description : Combinational opcode decoder producing pipeline controls,
//                operand-usage and illegal-opcode flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module main_decoder
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        unique case (opcode)
            OP_RTYPE: begin
                dec.ex.reg_write = 1'b1;
                dec.ex.alu_op    = ALUOP_FUNCT;
                dec.reg_dst      = 1'b1;
                dec.uses_rt      = 1'b1;
            end
            OP_LW: begin
                dec.ex.reg_write  = 1'b1;
                dec.ex.mem_read   = 1'b1;
                dec.ex.mem_to_reg = 1'b1;
                dec.ex.alu_src    = 1'b1;
                dec.ex.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                dec.ex.mem_write = 1'b1;
                dec.ex.alu_src   = 1'b1;
                dec.ex.alu_op    = ALUOP_ADD;
                dec.uses_rt      = 1'b1;
            end
            OP_BEQ: begin
                dec.ex.branch = 1'b1;
                dec.ex.alu_op = ALUOP_SUB;
                dec.uses_rt   = 1'b1;
            end
            OP_ADDI: begin
                dec.ex.reg_write = 1'b1;
                dec.ex.alu_src   = 1'b1;
                dec.ex.alu_op    = ALUOP_ADD;
            end
            OP_ORI: begin
                dec.ex.reg_write = 1'b1;
                dec.ex.alu_src   = 1'b1;
                dec.ex.alu_op    = ALUOP_OR;
                dec.zero_ext     = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

endmodule : main_decoder
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : Decode stage with WB bypass, load-use hazard detection and
//                the ID/EX pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              ifidValid,
    input  logic              flush,
    output logic [REG_AW-1:0] readReg1,
    output logic [REG_AW-1:0] readReg2,
    input  logic [DATA_W-1:0] readData1,
    input  logic [DATA_W-1:0] readData2,
    input  logic              wbRegWrite,
    input  logic [REG_AW-1:0] wbWriteReg,
    input  logic [DATA_W-1:0] wbWriteData,
    output logic              stall,
    output logic              exValid,
    output logic              exRegWrite,
    output logic              exMemRead,
    output logic              exMemWrite,
    output logic              exMemToReg,
    output logic              exBranch,
    output logic              exAluSrc,
    output logic [1:0]        exAluOp,
    output logic [REG_AW-1:0] exRs,
    output logic [REG_AW-1:0] exRt,
    output logic [REG_AW-1:0] exWriteReg,
    output logic [DATA_W-1:0] exA,
    output logic [DATA_W-1:0] exB,
    output logic [DATA_W-1:0] exImm,
    output logic [5:0]        exFunct,
    output logic              exIllegal
);

    import mips_pkg::*;

    dec_t              dec;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] imm;
    logic              hazard;
    logic              load_bubble;

    logic              valid_d,   valid_q;
    ex_ctrl_t          ctrl_d,    ctrl_q;
    logic              illegal_d, illegal_q;
    logic [REG_AW-1:0] rs_d,      rs_q;
    logic [REG_AW-1:0] rt_d,      rt_q;
    logic [REG_AW-1:0] wr_d,      wr_q;
    logic [DATA_W-1:0] a_d,       a_q;
    logic [DATA_W-1:0] b_d,       b_q;
    logic [DATA_W-1:0] imm_d,     imm_q;
    logic [5:0]        funct_d,   funct_q;

    main_decoder u_main_decoder (
        .opcode (instr[31:26]),
        .dec    (dec)
    );

    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign readReg1 = rs;
    assign readReg2 = rt;

    // Same-cycle WB write is not yet visible at the register file outputs
    assign op_a = (wbRegWrite && (wbWriteReg != '0) && (wbWriteReg == rs)) ? wbWriteData : readData1;
    assign op_b = (wbRegWrite && (wbWriteReg != '0) && (wbWriteReg == rt)) ? wbWriteData : readData2;

    assign imm = {{(DATA_W-16){instr[15] & ~dec.zero_ext}}, instr[15:0]};

    assign hazard = ifidValid && valid_q && ctrl_q.mem_read && (wr_q != '0) &&
                    ((wr_q == rs) || (dec.uses_rt && (wr_q == rt)));

    // A flush overrides the hazard: the dependent instruction is dead anyway
    assign stall       = hazard && !flush && !reset;
    assign load_bubble = flush || hazard || !ifidValid;

    always_comb begin
        valid_d   = 1'b1;
        ctrl_d    = dec.ex;
        illegal_d = dec.illegal;
        rs_d      = rs;
        rt_d      = rt;
        wr_d      = dec.reg_dst ? rd : rt;
        a_d       = op_a;
        b_d       = op_b;
        imm_d     = imm;
        funct_d   = instr[5:0];
        if (load_bubble) begin
            valid_d   = 1'b0;
            ctrl_d    = '0;
            illegal_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            wr_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            funct_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            wr_q      <= wr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            funct_q   <= funct_d;
        end
    end

    assign exValid    = valid_q;
    assign exRegWrite = ctrl_q.reg_write;
    assign exMemRead  = ctrl_q.mem_read;
    assign exMemWrite = ctrl_q.mem_write;
    assign exMemToReg = ctrl_q.mem_to_reg;
    assign exBranch   = ctrl_q.branch;
    assign exAluSrc   = ctrl_q.alu_src;
    assign exAluOp    = ctrl_q.alu_op;
    assign exRs       = rs_q;
    assign exRt       = rt_q;
    assign exWriteReg = wr_q;
    assign exA        = a_q;
    assign exB        = b_q;
    assign exImm      = imm_q;
    assign exFunct    = funct_q;
    assign exIllegal  = illegal_q;

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage against a behavioural
//                decode/hazard model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid, reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src;
        logic [1:0]  alu_op;
        logic [4:0]  rs, rt, wr;
        logic [31:0] a, b, imm;
        logic [5:0]  funct;
        logic        illegal;
    } exp_t;

    logic        Clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        ifidValid, flush;
    logic [4:0]  readReg1, readReg2;
    logic [31:0] readData1, readData2;
    logic        wbRegWrite;
    logic [4:0]  wbWriteReg;
    logic [31:0] wbWriteData;
    logic        stall, exValid, exRegWrite, exMemRead, exMemWrite, exMemToReg, exBranch, exAluSrc;
    logic [1:0]  exAluOp;
    logic [4:0]  exRs, exRt, exWriteReg;
    logic [31:0] exA, exB, exImm;
    logic [5:0]  exFunct;
    logic        exIllegal;

    exp_t act, mstate;
    logic exp_stall, obs_stall;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 Clk = ~Clk;

    id_ex_stage dut (
        .Clk(Clk), .reset(reset), .instr(instr), .ifidValid(ifidValid), .flush(flush),
        .readReg1(readReg1), .readReg2(readReg2), .readData1(readData1), .readData2(readData2),
        .wbRegWrite(wbRegWrite), .wbWriteReg(wbWriteReg), .wbWriteData(wbWriteData),
        .stall(stall), .exValid(exValid), .exRegWrite(exRegWrite), .exMemRead(exMemRead),
        .exMemWrite(exMemWrite), .exMemToReg(exMemToReg), .exBranch(exBranch), .exAluSrc(exAluSrc),
        .exAluOp(exAluOp), .exRs(exRs), .exRt(exRt), .exWriteReg(exWriteReg),
        .exA(exA), .exB(exB), .exImm(exImm), .exFunct(exFunct), .exIllegal(exIllegal)
    );

    assign act = {exValid, exRegWrite, exMemRead, exMemWrite, exMemToReg, exBranch, exAluSrc,
                  exAluOp, exRs, exRt, exWriteReg, exA, exB, exImm, exFunct, exIllegal};

    function automatic logic [31:0] mk_r(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                                         input logic [5:0] fn);
        return {6'h00, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                         input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    // Instruction-level meaning of each opcode, straight from the ISA table
    function automatic exp_t model_decode(input logic [31:0] i);
        exp_t e;
        logic [5:0] op;
        op       = i[31:26];
        e        = '0;
        e.valid  = 1'b1;
        e.rs     = i[25:21];
        e.rt     = i[20:16];
        e.wr     = i[20:16];
        e.funct  = i[5:0];
        e.imm    = 32'($signed(i[15:0]));
        e.a      = (wbRegWrite && wbWriteReg != 0 && wbWriteReg == e.rs) ? wbWriteData : readData1;
        e.b      = (wbRegWrite && wbWriteReg != 0 && wbWriteReg == e.rt) ? wbWriteData : readData2;
        case (op)
            6'h00: begin e.reg_write = 1; e.alu_op = 2'b10; e.wr = i[15:11]; end
            6'h23: begin e.reg_write = 1; e.mem_read = 1; e.mem_to_reg = 1; e.alu_src = 1; end
            6'h2B: begin e.mem_write = 1; e.alu_src = 1; end
            6'h04: begin e.branch = 1; e.alu_op = 2'b01; end
            6'h08: begin e.reg_write = 1; e.alu_src = 1; end
            6'h0D: begin e.reg_write = 1; e.alu_src = 1; e.alu_op = 2'b11; e.imm = {16'h0, i[15:0]}; end
            default: e.illegal = 1;
        endcase
        return e;
    endfunction

    function automatic logic model_hazard(input logic [31:0] i, input logic v);
        logic [5:0] op;
        logic       reads_rt;
        op       = i[31:26];
        reads_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        return v && mstate.valid && mstate.mem_read && mstate.wr != 0 &&
               (mstate.wr == i[25:21] || (reads_rt && mstate.wr == i[20:16]));
    endfunction

    // Data fields of a bubble are unspecified
    function automatic exp_t norm(input exp_t x);
        exp_t y;
        y = x;
        if (!y.valid) begin
            y.rs = 0; y.rt = 0; y.wr = 0; y.a = 0; y.b = 0; y.imm = 0; y.funct = 0;
        end
        return y;
    endfunction

    // One clock: drive ID inputs, sample stall mid-cycle, advance model at the edge
    task automatic tick(input logic [31:0] i, input logic v, input logic f);
        instr     = i;
        ifidValid = v;
        flush     = f;
        exp_stall = model_hazard(i, v) && !f;
        @(negedge Clk);
        obs_stall = stall;
        @(posedge Clk);
        if (f || exp_stall || !v) mstate = '0;
        else                      mstate = model_decode(i);
        #1;
    endtask

    task automatic test_reset;
        reset = 1; instr = mk_r(5'd1, 5'd2, 5'd3, 6'h20); ifidValid = 1; flush = 0;
        readData1 = 32'h11; readData2 = 32'h22; wbRegWrite = 0; wbWriteReg = 0; wbWriteData = 0;
        mstate = '0;
        repeat (2) @(posedge Clk);
        #1;
        vectors++;
        if (act !== '0) begin miscompares++; $display("FAIL reset_regs: got %h want 0", act); end
        vectors++;
        if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", stall); end
        reset = 0;
        tick(mk_r(5'd1, 5'd2, 5'd3, 6'h20), 1, 0);
        vectors++;
        if (exValid !== 1'b1 || exAluOp !== 2'b10 || exWriteReg !== 5'd3) begin
            miscompares++;
            $display("FAIL reset_first_add: got v=%b op=%b wr=%0d want v=1 op=10 wr=3", exValid, exAluOp, exWriteReg);
        end
        vectors++;
        if (norm(act) !== norm(mstate)) begin miscompares++; $display("FAIL reset_first_full: got %h want %h", act, mstate); end
    endtask

    task automatic test_load_use;
        tick(32'h0, 0, 0);
        tick(mk_i(6'h23, 5'd1, 5'd5, 16'h0), 1, 0);
        tick(mk_r(5'd5, 5'd2, 5'd6, 6'h20), 1, 0);
        vectors++;
        if (obs_stall !== 1'b1) begin miscompares++; $display("FAIL loaduse_stall: got %b want 1", obs_stall); end
        vectors++;
        if (exValid !== 1'b0) begin miscompares++; $display("FAIL loaduse_bubble: got exValid=%b want 0", exValid); end
        tick(mk_r(5'd5, 5'd2, 5'd6, 6'h20), 1, 0);
        vectors++;
        if (obs_stall !== 1'b0) begin miscompares++; $display("FAIL loaduse_release: got %b want 0", obs_stall); end
        vectors++;
        if (exValid !== 1'b1 || exRs !== 5'd5) begin
            miscompares++; $display("FAIL loaduse_issue: got v=%b rs=%0d want v=1 rs=5", exValid, exRs);
        end
        // sw depends on the loaded register through rt
        tick(mk_i(6'h23, 5'd1, 5'd7, 16'h0), 1, 0);
        tick(mk_i(6'h2B, 5'd2, 5'd7, 16'h4), 1, 0);
        vectors++;
        if (obs_stall !== 1'b1) begin miscompares++; $display("FAIL sw_rt_stall: got %b want 1", obs_stall); end
    endtask

    task automatic test_bypass;
        tick(32'h0, 0, 0);
        wbRegWrite = 1; wbWriteReg = 5'd21; wbWriteData = 32'hFFFF0000; readData1 = 32'h0; readData2 = 32'h5;
        tick(mk_i(6'h08, 5'd21, 5'd1, 16'h5), 1, 0);
        vectors++;
        if (exA !== 32'hFFFF0000) begin miscompares++; $display("FAIL bypass_rs21: got %h want FFFF0000", exA); end
        wbWriteReg = 5'd0; readData1 = 32'h00001234;
        tick(mk_i(6'h08, 5'd0, 5'd1, 16'h5), 1, 0);
        vectors++;
        if (exA !== 32'h00001234) begin miscompares++; $display("FAIL bypass_r0: got %h want 00001234", exA); end
        wbRegWrite = 0;
    endtask

    task automatic test_imm;
        tick(mk_i(6'h08, 5'd0, 5'd2, 16'hFFFF), 1, 0);
        vectors++;
        if (exImm !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL addi_imm: got %h want FFFFFFFF", exImm); end
        tick(mk_i(6'h0D, 5'd0, 5'd2, 16'hFFFF), 1, 0);
        vectors++;
        if (exImm !== 32'h0000FFFF || exAluOp !== 2'b11) begin
            miscompares++; $display("FAIL ori_imm: got imm=%h op=%b want 0000FFFF op=11", exImm, exAluOp);
        end
    endtask

    task automatic test_flush_hazard;
        tick(32'h0, 0, 0);
        tick(mk_i(6'h23, 5'd1, 5'd5, 16'h0), 1, 0);
        tick(mk_r(5'd5, 5'd2, 5'd6, 6'h20), 1, 1);
        vectors++;
        if (obs_stall !== 1'b0) begin miscompares++; $display("FAIL flush_stall: got %b want 0", obs_stall); end
        vectors++;
        if (norm(act) !== '0) begin miscompares++; $display("FAIL flush_bubble: got %h want bubble", act); end
    endtask

    task automatic test_illegal;
        tick({6'h3F, 26'h2A5A5A5}, 1, 0);
        vectors++;
        if (exIllegal !== 1'b1 || exValid !== 1'b1 ||
            {exRegWrite, exMemRead, exMemWrite, exMemToReg, exBranch, exAluSrc, exAluOp} !== 8'h0) begin
            miscompares++; $display("FAIL illegal: got %h want ill=1 v=1 ctrl=0", act);
        end
    endtask

    task automatic test_reset_mid_stall;
        tick(32'h0, 0, 0);
        tick(mk_i(6'h23, 5'd1, 5'd5, 16'h0), 1, 0);
        instr = mk_r(5'd5, 5'd2, 5'd6, 6'h20); ifidValid = 1; flush = 0;
        #2;
        vectors++;
        if (stall !== 1'b1) begin miscompares++; $display("FAIL midstall_pre: got %b want 1", stall); end
        reset = 1;
        #1;
        vectors++;
        if (act !== '0 || stall !== 1'b0) begin
            miscompares++; $display("FAIL midstall_reset: got regs=%h stall=%b want 0/0", act, stall);
        end
        ifidValid = 0;
        #1 reset = 0;
        mstate = '0;
        @(posedge Clk); #1;
        vectors++;
        if (norm(act) !== '0) begin miscompares++; $display("FAIL midstall_after: got %h want bubble", act); end
    endtask

    task automatic test_random;
        logic [5:0]  ops [8];
        logic [31:0] cur;
        logic        stalled;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0D, 6'h3F, 6'h23};
        stalled = 0;
        cur = 0;
        for (int n = 0; n < 200; n++) begin
            logic v, f;
            if (!stalled) begin
                cur = $urandom;
                cur[31:26] = ops[$urandom_range(0, 7)];
                cur[25:21] = 5'($urandom_range(0, 3));
                cur[20:16] = 5'($urandom_range(0, 3));
                cur[15:11] = 5'($urandom_range(0, 3));
                v = ($urandom_range(0, 9) != 0);
            end else begin
                v = 1;
            end
            f = ($urandom_range(0, 9) == 0);
            readData1   = $urandom;
            readData2   = $urandom;
            wbRegWrite  = 1'($urandom_range(0, 1));
            wbWriteReg  = 5'($urandom_range(0, 3));
            wbWriteData = $urandom;
            tick(cur, v, f);
            stalled = exp_stall;
            vectors++;
            if (obs_stall !== exp_stall) begin
                miscompares++; $display("FAIL rand_stall[%0d]: got %b want %b", n, obs_stall, exp_stall);
            end
            vectors++;
            if (norm(act) !== norm(mstate)) begin
                miscompares++; $display("FAIL rand_ex[%0d]: got %h want %h", n, act, mstate);
            end
        end
    endtask

    initial begin
        test_reset;
        test_load_use;
        test_bypass;
        test_imm;
        test_flush_hazard;
        test_illegal;
        test_reset_mid_stall;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_id_ex_stage
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode stage plus ID/EX pipeline register of the 5-stage MIPS core; sits between IF/ID and EX.
- Drives register-file read addresses, bypasses the WB write into operands, detects load-use hazards, and registers decoded controls/operands for EX.
- Shares the WB write bus that also feeds the register file.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register address width

Ports:
- Clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- instr  in  32  instruction from IF/ID
- ifidValid  in  1  instr is a real instruction
- flush  in  1  branch/jump taken; kill the instruction in ID
- readReg1  out  5  instr[25:21] to register file (combinational)
- readReg2  out  5  instr[20:16] to register file (combinational)
- readData1  in  32  register file port 1 data
- readData2  in  32  register file port 2 data
- wbRegWrite  in  1  WB write enable (same as register file regWrite)
- wbWriteReg  in  5  WB destination
- wbWriteData  in  32  WB data
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- exValid  out  1  ID/EX holds a real instruction
- exRegWrite, exMemRead, exMemWrite, exMemToReg, exBranch, exAluSrc  out  1 each  registered controls
- exAluOp  out  2  00 add, 01 sub, 10 use funct, 11 or
- exRs, exRt, exWriteReg  out  5 each  source regs; final destination after regDst mux
- exA, exB  out  32 each  operand values after WB bypass
- exImm  out  32  extended immediate
- exFunct  out  6  instr[5:0]
- exIllegal  out  1  registered unknown-opcode flag

Behaviour:
- Decoder (combinational, on instr[31:26]):
  - 0x00 R-type: regWrite, regDst=rd, aluOp=10, uses rt
  - 0x23 lw: regWrite, memRead, memToReg, aluSrc, add, dest rt
  - 0x2B sw: memWrite, aluSrc, add, uses rt
  - 0x04 beq: branch, sub, uses rt
  - 0x08 addi: regWrite, aluSrc, add, dest rt, sign-extend
  - 0x0D ori: regWrite, aluSrc, or, dest rt, zero-extend
  - other: all controls 0, illegal=1
- Immediate: sign-extended instr[15:0] except ori, which zero-extends.
- Bypass: operand A = wbWriteData when wbRegWrite && wbWriteReg!=0 && wbWriteReg==rs, else readData1. Operand B uses the same rule on rt. Register 0 is never bypassed.
- Hazard (load-use):
  - hazard = ifidValid && exValid && exMemRead && exWriteReg!=0 && (exWriteReg==rs || (usesRt && exWriteReg==rt)).
  - stall = hazard && !flush.
- ID/EX update priority per rising edge: reset > flush > stall > normal.
  - flush, stall, or !ifidValid: load a bubble. exValid, all controls and exIllegal go to 0; data fields may take any value.
  - normal: load decoded controls, exValid=1, exIllegal=illegal, operands, exImm, exFunct, exRs, exRt, exWriteReg.
  - An illegal instruction is loaded with exValid=1 and all controls 0.
- Reset (asynchronous): every registered output is 0. stall is 0 while reset is high.
- Latency: 1 cycle from ID to EX outputs. A stalled instruction remains at instr and is re-decoded the next cycle; bypass is re-evaluated on each retry.
- Simultaneous flush and hazard: flush wins, stall=0, bubble inserted.
- Reset mid-stall: state is cleared immediately and stall drops.

Decomposition:
- Shared package (mips_pkg): opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI), ALUOP_* encodings, DATA_W/REG_AW.
- One sub-module, main_decoder (combinational opcode→controls, usesRt, illegal). Pipeline register, bypass and hazard logic stay in id_ex_stage.

Test Plan:
- Reset with instr=add $3,$1,$2 → all ex* outputs 0, stall=0; after reset release, one edge gives exValid=1, exAluOp=10, exWriteReg=3.
- lw $5,0($1) then add $6,$5,$2 → stall=1 for exactly one cycle, ID/EX bubble (exValid=0), then add issues with exRs=5.
- wbRegWrite=1, wbWriteReg=21, wbWriteData=FFFF0000, readData1=0, instr rs=21 → exA=FFFF0000 next edge. Same with wbWriteReg=0 and rs=0 → exA=readData1.
- addi $2,$0,-1 → exImm=FFFFFFFF. ori $2,$0,0xFFFF → exImm=0000FFFF, exAluOp=11.
- Load-use hazard with flush=1 in the same cycle → stall=0, bubble loaded; sw after lw with a matching rt also stalls.
- Opcode 0x3F → exIllegal=1, exValid=1, all controls 0. Assert reset during a stall → outputs cleared asynchronously before the next edge.
